// File: rtl/intercpu_cluster_arb_pkg.sv
// intercpu_cluster_arb_pkg: shared FSM encoding and field widths
// for the inter-CPU ST cluster arbiter.
package intercpu_cluster_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam int JW = 3;
  localparam int CW = 3;
  localparam int DW = 64;

endpackage

// File: rtl/intercpu_rr_pick.sv
// intercpu_rr_pick: combinational round-robin selector,
// one-hot pick of the first request at or after ptr.
module intercpu_rr_pick #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick
);

  logic found;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[(int'(ptr) + i) % N]) begin
        pick[(int'(ptr) + i) % N] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intercpu_cluster_arb.sv
// intercpu_cluster_arb: round-robin arbiter for shared ST clusters.
// Define INTERCPU_ARB_LOCK_EN for the bounded per-CPU grant lock.
module intercpu_cluster_arb
  import intercpu_cluster_arb_pkg::*;
#(
  parameter int N_CPU    = 2,
  parameter int N_CLUS   = 3,
  parameter int LOCK_MAX = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CPU-1:0]      i_req,
  input  logic [N_CPU-1:0]      i_we,
  input  logic [CW*N_CPU-1:0]   i_cln,
  input  logic [JW*N_CPU-1:0]   i_j,
  input  logic [DW*N_CPU-1:0]   i_wdata,
  input  logic [N_CPU-1:0]      i_lock,
  input  logic [DW-1:0]         i_si,
  output logic [N_CPU-1:0]      o_gnt,
  output logic [N_CPU-1:0]      o_rvalid,
  output logic [DW-1:0]         o_rdata,
  output logic [N_CPU-1:0]      o_err,
  output logic [CW-1:0]         o_mux_cln,
  output logic [JW-1:0]         o_mux_j,
  output logic                  o_st_we,
  output logic [DW-1:0]         o_st_wdata
);

  localparam int PW = (N_CPU > 1) ? $clog2(N_CPU) : 1;

  arb_state_t state, state_d;

  logic [PW-1:0]    ptr, ptr_d;
  logic [PW-1:0]    sel, sel_d;
  logic [PW-1:0]    pidx;
  logic             we_q, we_d;
  logic             ok_q, ok_d;
  logic [CW-1:0]    cln_q, cln_d, pcln;
  logic [JW-1:0]    j_q, j_d;
  logic [DW-1:0]    wd_q, wd_d;
  logic [N_CPU-1:0] req_eff, pick;
  logic [N_CPU-1:0] gnt_d, rv_d, err_d;
  logic [DW-1:0]    rd_d, stwd_d;
  logic [CW-1:0]    mcln_d;
  logic [JW-1:0]    mj_d;
  logic             stwe_d;
  logic             lock_hold;

  intercpu_rr_pick #(
    .N  (N_CPU),
    .PW (PW)
  ) u_pick (
    .req  (req_eff),
    .ptr  (ptr),
    .pick (pick)
  );

  always_comb begin
    pidx = '0;
    for (int i = 0; i < N_CPU; i++) begin
      if (pick[i]) pidx = PW'(i);
    end
  end

  assign pcln = i_cln[pidx*CW +: CW];

`ifdef INTERCPU_ARB_LOCK_EN
  localparam int LW = $clog2(LOCK_MAX + 1);

  logic          lk_on, lk_on_d;
  logic [PW-1:0] lk_cpu, lk_cpu_d;
  logic [LW-1:0] lk_cnt, lk_cnt_d;

  // lock counts grants already given to the locking CPU
  assign lock_hold = lk_on && i_lock[lk_cpu]
                  && (lk_cnt < LW'(LOCK_MAX));
  assign req_eff = lock_hold
                 ? (i_req & (N_CPU'(1) << lk_cpu))
                 : i_req;

  always_comb begin
    lk_on_d  = lk_on;
    lk_cpu_d = lk_cpu;
    lk_cnt_d = lk_cnt;
    if (state == IDLE) begin
      if (!lock_hold) begin
        lk_on_d  = 1'b0;
        lk_cnt_d = '0;
      end
      if (|pick) begin
        if (lock_hold) begin
          lk_cnt_d = lk_cnt + 1'b1;
        end else if (i_lock[pidx]) begin
          lk_on_d  = 1'b1;
          lk_cpu_d = pidx;
          lk_cnt_d = LW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lk_on  <= 1'b0;
      lk_cpu <= '0;
      lk_cnt <= '0;
    end else begin
      lk_on  <= lk_on_d;
      lk_cpu <= lk_cpu_d;
      lk_cnt <= lk_cnt_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^i_lock;
  assign lock_hold   = 1'b0;
  assign req_eff     = i_req;
`endif

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    sel_d   = sel;
    we_d    = we_q;
    ok_d    = ok_q;
    cln_d   = cln_q;
    j_d     = j_q;
    wd_d    = wd_q;
    gnt_d   = '0;
    rv_d    = '0;
    err_d   = '0;
    rd_d    = o_rdata;
    mcln_d  = '0;
    mj_d    = '0;
    stwe_d  = 1'b0;
    stwd_d  = '0;
    unique case (state)
      IDLE: begin
        if (|pick) begin
          gnt_d   = pick;
          sel_d   = pidx;
          we_d    = i_we[pidx];
          cln_d   = pcln;
          j_d     = i_j[pidx*JW +: JW];
          wd_d    = i_wdata[pidx*DW +: DW];
          ok_d    = (pcln != '0) && (int'(pcln) <= N_CLUS);
          state_d = ACCESS;
          if (!lock_hold) begin
            ptr_d = (pidx == PW'(N_CPU - 1)) ? '0 : pidx + 1'b1;
          end
        end
      end
      ACCESS: begin
        mcln_d     = ok_q ? cln_q : '0;
        mj_d       = j_q;
        stwd_d     = wd_q;
        stwe_d     = we_q & ok_q;
        err_d[sel] = ~ok_q;
        state_d    = we_q ? IDLE : RESP;
      end
      RESP: begin
        rd_d      = ok_q ? i_si : '0;
        rv_d[sel] = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      sel        <= '0;
      we_q       <= 1'b0;
      ok_q       <= 1'b0;
      cln_q      <= '0;
      j_q        <= '0;
      wd_q       <= '0;
      o_gnt      <= '0;
      o_rvalid   <= '0;
      o_rdata    <= '0;
      o_err      <= '0;
      o_mux_cln  <= '0;
      o_mux_j    <= '0;
      o_st_we    <= 1'b0;
      o_st_wdata <= '0;
    end else begin
      state      <= state_d;
      ptr        <= ptr_d;
      sel        <= sel_d;
      we_q       <= we_d;
      ok_q       <= ok_d;
      cln_q      <= cln_d;
      j_q        <= j_d;
      wd_q       <= wd_d;
      o_gnt      <= gnt_d;
      o_rvalid   <= rv_d;
      o_rdata    <= rd_d;
      o_err      <= err_d;
      o_mux_cln  <= mcln_d;
      o_mux_j    <= mj_d;
      o_st_we    <= stwe_d;
      o_st_wdata <= stwd_d;
    end
  end

endmodule

// File: tb/tb_intercpu_cluster_arb.sv
// tb_intercpu_cluster_arb: directed and random checks against a
// cycle-schedule reference model of the cluster arbiter.
module tb_intercpu_cluster_arb;

  localparam int N    = 2;
  localparam int NCL  = 3;
  localparam int LMAX = 15;
  localparam int NC   = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  req, we, lk;
  logic [2:0]  cln [N];
  logic [2:0]  jj  [N];
  logic [63:0] wd  [N];

  logic [5:0]   i_cln, i_j;
  logic [127:0] i_wdata;
  logic [63:0]  si;
  logic [1:0]   o_gnt, o_rvalid, o_err;
  logic [63:0]  o_rdata, o_st_wdata;
  logic [2:0]   o_mux_cln, o_mux_j;
  logic         o_st_we;

  logic [63:0] mem [8][8];

  assign i_cln   = {cln[1], cln[0]};
  assign i_j     = {jj[1], jj[0]};
  assign i_wdata = {wd[1], wd[0]};
  assign si      = mem[o_mux_cln][o_mux_j];

  intercpu_cluster_arb #(
    .N_CPU(N), .N_CLUS(NCL), .LOCK_MAX(LMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(req), .i_we(we), .i_cln(i_cln), .i_j(i_j),
    .i_wdata(i_wdata), .i_lock(lk), .i_si(si),
    .o_gnt(o_gnt), .o_rvalid(o_rvalid), .o_rdata(o_rdata),
    .o_err(o_err), .o_mux_cln(o_mux_cln), .o_mux_j(o_mux_j),
    .o_st_we(o_st_we), .o_st_wdata(o_st_wdata)
  );

  logic         rst4 = 1'b1;
  logic [3:0]   req4 = '0;
  logic [3:0]   g4, rv4, err4;
  logic [63:0]  rd4, wd4o;
  logic [2:0]   mc4, mj4;
  logic         we4o;

  intercpu_cluster_arb #(
    .N_CPU(4), .N_CLUS(NCL), .LOCK_MAX(LMAX)
  ) dut4 (
    .clk(clk), .rst(rst4),
    .i_req(req4), .i_we(4'hF), .i_cln({4{3'd1}}), .i_j(12'd0),
    .i_wdata(256'd0), .i_lock(4'd0), .i_si(64'd0),
    .o_gnt(g4), .o_rvalid(rv4), .o_rdata(rd4),
    .o_err(err4), .o_mux_cln(mc4), .o_mux_j(mj4),
    .o_st_we(we4o), .o_st_wdata(wd4o)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // expected outputs per cycle, filled when a grant is predicted
  logic [1:0]  e_gnt [NC];
  logic [1:0]  e_rv  [NC];
  logic [1:0]  e_err [NC];
  logic [2:0]  e_mc  [NC];
  logic [2:0]  e_mj  [NC];
  logic        e_we  [NC];
  logic [63:0] e_wd  [NC];
  logic [63:0] e_rd  [NC];
  logic        e_rs  [NC];

  int n = 0;
  int free = 0;
  int ptr_m = 0;
  int last_w = -1;
  int lk_on = 0;
  int lk_cpu = 0;
  int lk_n = 0;
  logic [63:0] m_rd = '0;

  task automatic clr(input int k);
    e_gnt[k] = '0; e_rv[k] = '0; e_err[k] = '0;
    e_mc[k] = '0; e_mj[k] = '0; e_we[k] = 1'b0;
    e_wd[k] = '0; e_rd[k] = '0; e_rs[k] = 1'b0;
  endtask

  task automatic model_edge();
    int w;
    bit hold;
    bit ok;
    logic [1:0] one;
    last_w = -1;
    if (rst) begin
      for (int k = n; k < n + 3; k++) clr(k);
      e_rs[n] = 1'b1;
      free = n + 1;
      ptr_m = 0;
      lk_on = 0;
      lk_n = 0;
      return;
    end
    if (n < free) return;
    hold = 1'b0;
`ifdef INTERCPU_ARB_LOCK_EN
    hold = (lk_on != 0) && lk[lk_cpu] && (lk_n < LMAX);
`endif
    if (!hold) begin
      lk_on = 0;
      lk_n = 0;
    end
    w = -1;
    if (hold) begin
      if (req[lk_cpu]) w = lk_cpu;
    end else begin
      for (int k = 0; k < N; k++)
        if (w < 0 && req[(ptr_m + k) % N]) w = (ptr_m + k) % N;
    end
    if (w < 0) return;
    last_w = w;
    ok = (cln[w] != 0) && (cln[w] <= NCL);
    one = '0;
    one[w] = 1'b1;
    e_gnt[n]   = one;
    e_mc[n+1]  = ok ? cln[w] : 3'd0;
    e_mj[n+1]  = jj[w];
    e_we[n+1]  = we[w] && ok;
    e_wd[n+1]  = wd[w];
    e_err[n+1] = ok ? 2'b00 : one;
    if (!we[w]) begin
      e_rv[n+2] = one;
      e_rs[n+2] = 1'b1;
      e_rd[n+2] = ok ? mem[cln[w]][jj[w]] : 64'd0;
    end
    if (hold) begin
      lk_n++;
    end else begin
      ptr_m = (w + 1) % N;
`ifdef INTERCPU_ARB_LOCK_EN
      if (lk[w]) begin
        lk_on = 1;
        lk_cpu = w;
        lk_n = 1;
      end
`endif
    end
    free = n + (we[w] ? 2 : 3);
  endtask

  task automatic check_out();
    if (e_rs[n]) m_rd = e_rd[n];
    chk("gnt", o_gnt, e_gnt[n]);
    chk("rvalid", o_rvalid, e_rv[n]);
    chk("err", o_err, e_err[n]);
    chk("mux_cln", o_mux_cln, e_mc[n]);
    chk("mux_j", o_mux_j, e_mj[n]);
    chk("st_we", o_st_we, e_we[n]);
    chk("st_wdata", o_st_wdata, e_wd[n]);
    chk("rdata", o_rdata, m_rd);
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    check_out();
    n++;
  endtask

  task automatic set_cpu(input int c, input logic w, input logic [2:0] cl,
                         input logic [2:0] j, input logic [63:0] d);
    we[c] = w; cln[c] = cl; jj[c] = j; wd[c] = d;
  endtask

  int q[$];
  int bound;
  int ex;

  initial begin
    for (int k = 0; k < NC; k++) clr(k);
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        mem[a][b] = {$urandom, $urandom} | 64'h1;
    mem[1][3] = 64'hA5;
    req = '0; we = '0; lk = '0;
    for (int c = 0; c < N; c++) set_cpu(c, 1'b0, 3'd0, 3'd0, 64'd0);

    rst = 1'b1;
    cyc();
    cyc();
    chk("reset_gnt", o_gnt, 2'b00);
    chk("reset_rdata", o_rdata, 64'd0);
    rst = 1'b0;
    cyc();

    // single read, CPU0 cln1 j3
    set_cpu(0, 1'b0, 3'd1, 3'd3, 64'd0);
    req[0] = 1'b1;
    cyc();
    chk("t1_gnt", o_gnt, 2'b01);
    req[0] = 1'b0;
    cyc();
    chk("t1_mux", {o_mux_cln, o_mux_j}, {3'd1, 3'd3});
    chk("t1_rv_early", o_rvalid, 2'b00);
    cyc();
    chk("t1_rvalid", o_rvalid, 2'b01);
    chk("t1_rdata", o_rdata, 64'hA5);
    cyc();

    // single write, CPU1 cln2 j7
    set_cpu(1, 1'b1, 3'd2, 3'd7, 64'h1234);
    req[1] = 1'b1;
    cyc();
    chk("t2_gnt", o_gnt, 2'b10);
    req[1] = 1'b0;
    cyc();
    chk("t2_we", o_st_we, 1'b1);
    chk("t2_mux", {o_mux_cln, o_mux_j}, {3'd2, 3'd7});
    chk("t2_wdata", o_st_wdata, 64'h1234);
    cyc();
    chk("t2_we_off", o_st_we, 1'b0);
    chk("t2_no_rv", o_rvalid, 2'b00);
    cyc();

    // invalid clusters 0 and N_CLUS+1
    for (int t = 0; t < 2; t++) begin
      set_cpu(0, 1'b0, (t == 0) ? 3'd0 : 3'(NCL + 1), 3'd5, 64'd0);
      req[0] = 1'b1;
      cyc();
      chk("t4_gnt", o_gnt, 2'b01);
      req[0] = 1'b0;
      cyc();
      chk("t4_err", o_err, 2'b01);
      chk("t4_cln", o_mux_cln, 3'd0);
      chk("t4_we", o_st_we, 1'b0);
      cyc();
      chk("t4_rvalid", o_rvalid, 2'b01);
      chk("t4_rdata", o_rdata, 64'd0);
      cyc();
    end

    // reset during ACCESS of a write
    set_cpu(0, 1'b1, 3'd1, 3'd2, 64'hBEEF);
    req[0] = 1'b1;
    cyc();
    req[0] = 1'b0;
    rst = 1'b1;
    cyc();
    chk("t5_we", o_st_we, 1'b0);
    chk("t5_out", {o_gnt, o_err, o_rvalid, o_mux_cln, o_mux_j}, '0);
    chk("t5_wdata", o_st_wdata, 64'd0);
    rst = 1'b0;
    cyc();
    cyc();
    chk("t5_we_after", o_st_we, 1'b0);

    // continuous requests from both CPUs
    q.delete();
    req = 2'b11;
    for (int t = 0; t < 40; t++) begin
      cyc();
      if (o_gnt != 2'b00) q.push_back(int'(o_gnt[1]));
      if (last_w >= 0)
        set_cpu(last_w, 1'($urandom_range(1)), 3'($urandom_range(3)),
                3'($urandom_range(7)), {$urandom, $urandom});
    end
    req = 2'b00;
    chk("t3_count", 64'(q.size() >= 8), 64'd1);
    for (int k = 0; k < 8 && k < q.size(); k++)
      chk("t3_seq", 64'(q[k]), 64'(k % 2));
    for (int t = 0; t < 4; t++) cyc();

    // CPU1 holds i_lock while both request
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int c = 0; c < N; c++) set_cpu(c, 1'b1, 3'd1, 3'(c), 64'(c));
    lk = 2'b10;
    req = 2'b11;
    q.delete();
    bound = 0;
    while (q.size() < LMAX + 2 && bound < 200) begin
      cyc();
      if (o_gnt != 2'b00) q.push_back(int'(o_gnt[1]));
      bound++;
    end
    chk("t6_bound", 64'(q.size()), 64'(LMAX + 2));
    for (int k = 0; k < q.size(); k++) begin
`ifdef INTERCPU_ARB_LOCK_EN
      ex = (k == 0 || k == LMAX + 1) ? 0 : 1;
`else
      ex = k % 2;
`endif
      chk("t6_seq", 64'(q[k]), 64'(ex));
    end
    req = 2'b00;
    lk = 2'b00;
    for (int t = 0; t < 4; t++) cyc();

    // randomized traffic
    for (int t = 0; t < 1500; t++) begin
      cyc();
      for (int c = 0; c < N; c++) begin
        if (last_w == c) req[c] = 1'b0;
        if (!req[c] && $urandom_range(2) == 0) begin
          req[c] = 1'b1;
          set_cpu(c, 1'($urandom_range(1)), 3'($urandom_range(7)),
                  3'($urandom_range(7)), {$urandom, $urandom});
        end
        if ($urandom_range(7) == 0) lk[c] = ~lk[c];
      end
    end
    req = 2'b00;
    lk = 2'b00;
    for (int t = 0; t < 4; t++) cyc();

    // four-CPU pointer wrap
    rst4 = 1'b0;
    req4 = 4'hF;
    q.delete();
    bound = 0;
    while (q.size() < 8 && bound < 100) begin
      cyc();
      for (int c = 0; c < 4; c++)
        if (g4[c]) q.push_back(c);
      bound++;
    end
    chk("n4_bound", 64'(q.size()), 64'd8);
    for (int k = 0; k < q.size(); k++)
      chk("n4_seq", 64'(q[k]), 64'(k % 4));
    req4 = '0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
